uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised receive buffer between the UART receiver FSM and the host.
//  Replaces the single-entry output register stage with a DEPTH-entry FIFO.
//  Each entry holds a data word plus its parity and framing error flags.
//  Adds valid/ready handshake, a sticky overflow flag, an optional drop-on-error
//  mode and a saturating error counter.
// PARAMETERS
//  DATA_WIDTH  8  width of a received word
//  DEPTH       4  FIFO entries; power of 2, >= 2
//  DROP_ERR    0  1: words with perror|ferror are counted, not stored
//  CNT_WIDTH   8  width of err_count
// PORTS
//  clk          in   1                 system clock, rising edge
//  reset        in   1                 asynchronous, active-low reset
//  in_data      in   DATA_WIDTH        received word from receiver FSM
//  in_perror    in   1                 parity error for in_data
//  in_ferror    in   1                 framing error for in_data
//  in_valid     in   1                 1-cycle strobe: in_* valid this cycle
//  out_data     out  DATA_WIDTH        head-of-FIFO word
//  out_perror   out  1                 head entry parity error flag
//  out_ferror   out  1                 head entry framing error flag
//  out_valid    out  1                 FIFO non-empty; out_* meaningful
//  out_ready    in   1                 consumer accepts head this cycle
//  level        out  log2(DEPTH)+1     number of stored entries, 0..DEPTH
//  overflow     out  1                 sticky: a word was lost because FIFO full
//  clr_status   in   1                 sync clear of overflow and err_count
//  err_count    out  CNT_WIDTH         saturating count of words with any error
// BEHAVIOUR
//  Reset (reset=0, async): pointers=0, level=0, out_valid=0,
//   out_data/out_perror/out_ferror=0, overflow=0, err_count=0. Storage is not cleared.
//  push = in_valid & ~(DROP_ERR & (in_perror|in_ferror)).
//  pop = out_valid & out_ready.
//  Write: on push with space (level<DEPTH, or level==DEPTH with pop in the same cycle),
//   store {in_perror,in_ferror,in_data} at wr_ptr and increment wr_ptr mod DEPTH.
//  Read: first-word fall-through. out_* come combinationally from mem[rd_ptr].
//   out_valid = (level!=0). On pop, increment rd_ptr mod DEPTH.
//  Latency: word strobed at edge N is on out_* with out_valid=1 in the cycle after edge N.
//  out_* hold stable while out_valid=1 and out_ready=0.
//  level: +1 on accepted push only, -1 on pop only, unchanged on both.
//  Full and push without pop: word dropped, pointers and level unchanged,
//   overflow<=1 at that edge.
//  Full with push and pop in the same cycle: both succeed, no overflow.
//  Empty with out_ready=1: no pop, rd_ptr unchanged.
//  Empty with push: no bypass; the word appears next cycle.
//  err_count increments on in_valid&(in_perror|in_ferror), whether the word is stored,
//   dropped by DROP_ERR, or lost to overflow. It saturates at 2^CNT_WIDTH-1.
//  clr_status=1 clears overflow and err_count at the edge. An error or overflow in the
//   same cycle takes priority: result is overflow=1 or err_count=1.
//  Reset mid-operation: all contents are discarded. out_valid drops immediately
//   (asynchronously).
//  Pointers are log2(DEPTH) bits and wrap naturally. level is kept as an explicit counter.
// TESTING
//  1) Reset, strobe 0xA5 (no err), out_ready=0 -> next cycle out_valid=1, out_data=0xA5,
//     level=1. Hold for 5 cycles, then out_ready=1 for 1 cycle -> level=0, out_valid=0.
//  2) DEPTH=4: push 0x01..0x05 with out_ready=0 -> level=4, overflow=1. Pop 4 times ->
//     0x01,0x02,0x03,0x04 in order. 0x05 is lost.
//  3) Full plus a simultaneous push 0x10 and pop -> head advances, 0x10 stored, level
//     stays 4, overflow stays 0.
//  4) DROP_ERR=1: push 0x11 with perror=1, then 0x22 clean -> only 0x22 is output,
//     err_count=1. With DROP_ERR=0, 0x11 is output with out_perror=1.
//  5) CNT_WIDTH=2: 5 framing-error words -> err_count=3 (saturated). clr_status
//     -> err_count=0, overflow=0.
//  6) reset asserted mid-stream with level=3 -> out_valid=0 and level=0 immediately.
//     After release, new pushes start at entry 0 with correct order.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: handshake and status bundle between the
// UART receiver FSM, the receive FIFO and the host.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_perror;
    logic                  in_ferror;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_perror;
    logic                  out_ferror;
    logic                  out_valid;
    logic                  out_ready;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  clr_status;
    logic [CNT_WIDTH-1:0]  err_count;

    modport master (
        output in_data, in_perror, in_ferror, in_valid,
        output out_ready, clr_status,
        input  out_data, out_perror, out_ferror, out_valid,
        input  level, overflow, err_count
    );

    modport slave (
        input  in_data, in_perror, in_ferror, in_valid,
        input  out_ready, clr_status,
        output out_data, out_perror, out_ferror, out_valid,
        output level, overflow, err_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry first-word fall-through receive buffer
// with error flags, sticky overflow and saturating error counter.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int DROP_ERR   = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic DROP = (DROP_ERR != 0);

    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic          bad;
    logic          err;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          lost;
    logic          valid;
    logic [EW-1:0] head;

    assign bad   = bus.in_perror | bus.in_ferror;
    assign err   = bus.in_valid & bad;
    assign push  = bus.in_valid & ~(DROP & bad);
    assign valid = (level_q != '0);
    assign pop   = valid & bus.out_ready;
    assign full  = (level_q == FULL_LVL);
    assign wr_en = push & (~full | pop);
    assign lost  = push & full & ~pop;
    assign head  = valid ? mem_q[rd_ptr_q] : '0;

    assign bus.out_data   = head[DATA_WIDTH-1:0];
    assign bus.out_ferror = head[DATA_WIDTH];
    assign bus.out_perror = head[DATA_WIDTH+1];
    assign bus.out_valid  = valid;
    assign bus.level      = level_q;
    assign bus.overflow   = ovf_q;
    assign bus.err_count  = cnt_q;

    // Next-state for pointers, fill level and status.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d = lost | (ovf_q & ~bus.clr_status);
        cnt_d = bus.clr_status ? '0 : cnt_q;
        if (err && cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_WIDTH'(1);
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_perror, bus.in_ferror,
                                bus.in_data};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus on two FIFO configurations
// (keep-on-error / 8-bit count and drop-on-error / 2-bit count).
module tb_uart_rx_fifo;
    logic       clk;
    logic       rst_n;
    logic [7:0] d_r;
    logic       pe_r, fe_r, iv_r, rdy_r, clr_r;
    int         checks;
    int         errors;
    bit         cmp_en;

    uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) ifa ();
    uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(2)) ifb ();

    assign ifa.in_data    = d_r;
    assign ifa.in_perror  = pe_r;
    assign ifa.in_ferror  = fe_r;
    assign ifa.in_valid   = iv_r;
    assign ifa.out_ready  = rdy_r;
    assign ifa.clr_status = clr_r;
    assign ifb.in_data    = d_r;
    assign ifb.in_perror  = pe_r;
    assign ifb.in_ferror  = fe_r;
    assign ifb.in_valid   = iv_r;
    assign ifb.out_ready  = rdy_r;
    assign ifb.clr_status = clr_r;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(4), .DROP_ERR(0),
                   .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(rst_n), .bus(ifa));

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(4), .DROP_ERR(1),
                   .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of {perror, ferror, data} per instance.
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    bit         ova, ovb;
    int         eca, ecb;

    always @(posedge clk or negedge rst_n) begin
        bit e;
        bit popa, popb, pa, pb;
        int sa, sb;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            ova = 0; ovb = 0; eca = 0; ecb = 0;
        end else begin
            e  = iv_r && (pe_r || fe_r);
            pa = iv_r;
            pb = iv_r && !e;
            sa = qa.size();
            sb = qb.size();
            popa = rdy_r && sa != 0;
            popb = rdy_r && sb != 0;
            if (popa) void'(qa.pop_front());
            if (popb) void'(qb.pop_front());
            if (clr_r) begin
                ova = 0; ovb = 0; eca = 0; ecb = 0;
            end
            if (pa) begin
                if (sa < 4 || popa) qa.push_back({pe_r, fe_r, d_r});
                else ova = 1;
            end
            if (pb) begin
                if (sb < 4 || popb) qb.push_back({pe_r, fe_r, d_r});
                else ovb = 1;
            end
            if (e && eca < 255) eca = eca + 1;
            if (e && ecb < 3) ecb = ecb + 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h @%0t",
                     n, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        logic [9:0] ha, hb;
        if (cmp_en) begin
            ha = (qa.size() != 0) ? qa[0] : 10'h0;
            hb = (qb.size() != 0) ? qb[0] : 10'h0;
            chk("A_valid", 32'(ifa.out_valid), 32'(qa.size() != 0));
            chk("A_data",  32'(ifa.out_data),  32'(ha[7:0]));
            chk("A_perr",  32'(ifa.out_perror), 32'(ha[9]));
            chk("A_ferr",  32'(ifa.out_ferror), 32'(ha[8]));
            chk("A_level", 32'(ifa.level),     32'(qa.size()));
            chk("A_ovf",   32'(ifa.overflow),  32'(ova));
            chk("A_ecnt",  32'(ifa.err_count), 32'(eca));
            chk("B_valid", 32'(ifb.out_valid), 32'(qb.size() != 0));
            chk("B_data",  32'(ifb.out_data),  32'(hb[7:0]));
            chk("B_perr",  32'(ifb.out_perror), 32'(hb[9]));
            chk("B_ferr",  32'(ifb.out_ferror), 32'(hb[8]));
            chk("B_level", 32'(ifb.level),     32'(qb.size()));
            chk("B_ovf",   32'(ifb.overflow),  32'(ovb));
            chk("B_ecnt",  32'(ifb.err_count), 32'(ecb));
        end
    end

    task automatic tick(input bit v, input bit pe, input bit fe,
                        input logic [7:0] d, input bit rdy,
                        input bit clr);
        iv_r = v; pe_r = pe; fe_r = fe; d_r = d;
        rdy_r = rdy; clr_r = clr;
        @(posedge clk);
        #1;
        iv_r = 0; pe_r = 0; fe_r = 0; d_r = 0;
        rdy_r = 0; clr_r = 0;
    endtask

    task automatic push(input logic [7:0] d);
        tick(1, 0, 0, d, 0, 0);
    endtask

    task automatic idle(input bit rdy);
        tick(0, 0, 0, 8'h00, rdy, 0);
    endtask

    task automatic pop_exp(input string n, input logic [7:0] d);
        chk(n, 32'(ifa.out_data), 32'(d));
        idle(1);
    endtask

    initial begin
        checks = 0; errors = 0; cmp_en = 0;
        rst_n = 0;
        d_r = 0; pe_r = 0; fe_r = 0; iv_r = 0; rdy_r = 0; clr_r = 0;
        #12;
        cmp_en = 1;
        chk("rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_level", 32'(ifa.level), 32'd0);
        chk("rst_data",  32'(ifa.out_data), 32'd0);
        chk("rst_ovf",   32'(ifa.overflow), 32'd0);
        chk("rst_ecnt",  32'(ifa.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // 1) single word, held, then popped
        push(8'hA5);
        chk("t1_valid", 32'(ifa.out_valid), 32'd1);
        chk("t1_data",  32'(ifa.out_data), 32'hA5);
        chk("t1_level", 32'(ifa.level), 32'd1);
        for (int i = 0; i < 5; i++) idle(0);
        chk("t1_hold", 32'(ifa.out_data), 32'hA5);
        idle(1);
        chk("t1_empty", 32'(ifa.out_valid), 32'd0);
        chk("t1_lvl0",  32'(ifa.level), 32'd0);

        // 2) overflow: fifth word lost
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("t2_level", 32'(ifa.level), 32'd4);
        chk("t2_ovf",   32'(ifa.overflow), 32'd1);
        for (int i = 1; i <= 4; i++) pop_exp("t2_order", 8'(i));
        chk("t2_lvl0", 32'(ifa.level), 32'd0);
        chk("t2_ovf_sticky", 32'(ifa.overflow), 32'd1);
        idle(1);
        chk("t2_pop_empty", 32'(ifa.level), 32'd0);
        tick(0, 0, 0, 8'h00, 0, 1);
        chk("t2_clr", 32'(ifa.overflow), 32'd0);

        // 3) full with simultaneous push and pop
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        tick(1, 0, 0, 8'h10, 1, 0);
        chk("t3_level", 32'(ifa.level), 32'd4);
        chk("t3_ovf",   32'(ifa.overflow), 32'd0);
        pop_exp("t3_h0", 8'h21);
        pop_exp("t3_h1", 8'h22);
        pop_exp("t3_h2", 8'h23);
        pop_exp("t3_h3", 8'h10);

        // 4) drop-on-error versus keep-on-error
        tick(1, 1, 0, 8'h11, 0, 0);
        push(8'h22);
        chk("t4_A_data", 32'(ifa.out_data), 32'h11);
        chk("t4_A_perr", 32'(ifa.out_perror), 32'd1);
        chk("t4_B_data", 32'(ifb.out_data), 32'h22);
        chk("t4_B_lvl",  32'(ifb.level), 32'd1);
        chk("t4_B_ecnt", 32'(ifb.err_count), 32'd1);
        idle(1);
        idle(1);
        chk("t4_drained", 32'(ifa.level), 32'd0);

        // 5) saturation, clear, clear-versus-error priority
        tick(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++)
            tick(1, 0, 1, 8'h30 + 8'(i), 1, 0);
        chk("t5_B_sat", 32'(ifb.err_count), 32'd3);
        chk("t5_A_cnt", 32'(ifa.err_count), 32'd5);
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        chk("t5_A_ovf", 32'(ifa.overflow), 32'd1);
        tick(0, 0, 0, 8'h00, 0, 1);
        chk("t5_clr_cnt", 32'(ifb.err_count), 32'd0);
        chk("t5_clr_ovf", 32'(ifa.overflow), 32'd0);
        tick(1, 0, 1, 8'h50, 0, 1);
        chk("t5_prio_cnt", 32'(ifa.err_count), 32'd1);
        chk("t5_prio_ovf", 32'(ifa.overflow), 32'd1);
        for (int i = 0; i < 4; i++) idle(1);

        // 6) asynchronous reset mid-stream
        push(8'h61); push(8'h62); push(8'h63);
        chk("t6_level3", 32'(ifa.level), 32'd3);
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_valid", 32'(ifa.out_valid), 32'd0);
        chk("t6_async_level", 32'(ifa.level), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        push(8'h71); push(8'h72);
        pop_exp("t6_n0", 8'h71);
        pop_exp("t6_n1", 8'h72);
        chk("t6_end", 32'(ifa.level), 32'd0);

        idle(0);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
